// File: rtl/mem_msg_pkg.sv
// Shared message types for the val/rdy memory request/response interface.
// MEM_RESPONDER_ALIGN_CHECK_EN adds an alignment-error flag to responses.
package mem_msg_pkg;

    localparam int DATA_W = 32;

    localparam logic MEM_TYPE_READ  = 1'b0;
    localparam logic MEM_TYPE_WRITE = 1'b1;

    typedef struct packed {
        logic              msg_type;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic              msg_type;
        logic [DATA_W-1:0] data;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        logic              err;
`endif
    } mem_resp_t;

endpackage

// File: rtl/mem_register.sv
// Generic enable register with asynchronous active-high reset to a fixed value.
module mem_register #(
    parameter int         W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State register: load d when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order response FIFO; DEPTH need not be a power of two.
// Enqueue into a full queue is accepted when a dequeue happens in the same cycle.
module mem_resp_queue
    import mem_msg_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enq,
    input  mem_resp_t enq_data,
    input  logic      deq,
    output logic      full,
    output logic      empty,
    output mem_resp_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_s, rd_ptr_s, wr_ptr_next_s, rd_ptr_next_s;
    logic [CNT_W-1:0] occ_s, occ_next_s;
    logic             enq_ok_s, deq_ok_s;
    mem_resp_t        slots_r [DEPTH];

    assign empty    = (occ_s == '0);
    assign full     = (occ_s == DEPTH_C);
    assign deq_ok_s = deq & ~empty;
    assign enq_ok_s = enq & (~full | deq);
    assign head     = slots_r[rd_ptr_s];

    // Pointer wrap and occupancy update.
    always_comb begin
        wr_ptr_next_s = wr_ptr_s;
        rd_ptr_next_s = rd_ptr_s;
        occ_next_s    = occ_s;
        if (wr_ptr_s == LAST_PTR) begin
            wr_ptr_next_s = '0;
        end else begin
            wr_ptr_next_s = wr_ptr_s + PTR_W'(1);
        end
        if (rd_ptr_s == LAST_PTR) begin
            rd_ptr_next_s = '0;
        end else begin
            rd_ptr_next_s = rd_ptr_s + PTR_W'(1);
        end
        case ({enq_ok_s, deq_ok_s})
            2'b10:   occ_next_s = occ_s + CNT_W'(1);
            2'b01:   occ_next_s = occ_s - CNT_W'(1);
            default: occ_next_s = occ_s;
        endcase
    end

    mem_register #(.W(PTR_W)) u_wr_ptr (
        .clk(clk), .rst(rst), .en(enq_ok_s), .d(wr_ptr_next_s), .q(wr_ptr_s)
    );

    mem_register #(.W(PTR_W)) u_rd_ptr (
        .clk(clk), .rst(rst), .en(deq_ok_s), .d(rd_ptr_next_s), .q(rd_ptr_s)
    );

    mem_register #(.W(CNT_W)) u_occ (
        .clk(clk), .rst(rst), .en(1'b1), .d(occ_next_s), .q(occ_s)
    );

    // Entry storage, written at the tail on enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
        end else if (enq_ok_s) begin
            slots_r[wr_ptr_s] <= enq_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency val/rdy memory responder over a word-addressed array.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to add memresp_err and reject misaligned requests.
module mem_responder
    import mem_msg_pkg::*;
#(
    parameter int WORDS  = 256,
    parameter int LAT    = 1,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreq_val,
    output logic              memreq_rdy,
    input  logic              memreq_type,
    input  logic [31:0]       memreq_addr,
    input  logic [DATA_W-1:0] memreq_wdata,
    output logic              memresp_val,
    input  logic              memresp_rdy,
    output logic              memresp_type,
    output logic [DATA_W-1:0] memresp_data
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic              memresp_err
`endif
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam int RESP_W = $bits(mem_resp_t);
    localparam int PIPE_W = RESP_W + 1;
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

    logic [DATA_W-1:0] mem_r [WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic              req_fire_s, resp_fire_s, misalign_s, wr_en_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              rdy_r;
    mem_resp_t         resp_in_s, enq_data_s, head_s;
    logic              q_full_s, q_empty_s;
    logic [PIPE_W-1:0] stage_s [LAT];
    logic              unused_addr_s;

    assign idx_s         = memreq_addr[IDX_W+1:2];
    assign unused_addr_s = ^{memreq_addr[31:IDX_W+2], memreq_addr[1:0], q_full_s};
    assign req_fire_s    = memreq_val & rdy_r;
    assign resp_fire_s   = ~q_empty_s & memresp_rdy;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign misalign_s = |memreq_addr[1:0];
`else
    assign misalign_s = 1'b0;
`endif

    assign wr_en_s = req_fire_s & (memreq_type == MEM_TYPE_WRITE) & ~misalign_s;

    // Build the response for the request presented this cycle.
    always_comb begin
        resp_in_s          = '0;
        resp_in_s.msg_type = memreq_type;
        if ((memreq_type == MEM_TYPE_READ) && !misalign_s) begin
            resp_in_s.data = mem_r[idx_s];
        end else begin
            resp_in_s.data = '0;
        end
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        resp_in_s.err = misalign_s;
`endif
    end

    // Array write at the request-fire edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= memreq_wdata;
        end
    end

    // The queue write acts as the final latency stage, so only LAT-1 registers precede it.
    assign stage_s[0] = {req_fire_s, resp_in_s};

    for (genvar g = 1; g < LAT; g++) begin : g_lat
        mem_register #(.W(PIPE_W)) u_stage (
            .clk(clk), .rst(rst), .en(1'b1), .d(stage_s[g-1]), .q(stage_s[g])
        );
    end

    assign enq_data_s = mem_resp_t'(stage_s[LAT-1][RESP_W-1:0]);

    mem_resp_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .enq     (stage_s[LAT-1][PIPE_W-1]),
        .enq_data(enq_data_s),
        .deq     (resp_fire_s),
        .full    (q_full_s),
        .empty   (q_empty_s),
        .head    (head_s)
    );

    // Outstanding-request count across pipeline and queue.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({req_fire_s, resp_fire_s})
            2'b10:   cnt_next_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_next_s = cnt_r - CNT_W'(1);
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Ready is held low through reset and derived from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            rdy_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            rdy_r <= (cnt_next_s < QDEPTH_C);
        end
    end

    assign memreq_rdy   = rdy_r;
    assign memresp_val  = ~q_empty_s;
    assign memresp_type = head_s.msg_type;
    assign memresp_data = head_s.data;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign memresp_err  = head_s.err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LAT=1 instance and a LAT=3 instance.
// Alignment-check cases run when MEM_RESPONDER_ALIGN_CHECK_EN is defined.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        req_val, req_type, resp_rdy, req_rdy, resp_val, resp_type;
    logic [31:0] req_addr, req_wdata, resp_data;
    logic        req_val3, req_type3, resp_rdy3, req_rdy3, resp_val3, resp_type3;
    logic [31:0] req_addr3, req_wdata3, resp_data3;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic        resp_err, resp_err3;
`endif
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORDS(256), .LAT(1), .QDEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .memreq_val(req_val), .memreq_rdy(req_rdy), .memreq_type(req_type),
        .memreq_addr(req_addr), .memreq_wdata(req_wdata),
        .memresp_val(resp_val), .memresp_rdy(resp_rdy),
        .memresp_type(resp_type), .memresp_data(resp_data)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        , .memresp_err(resp_err)
`endif
    );

    mem_responder #(.WORDS(256), .LAT(3), .QDEPTH(2)) u_dut3 (
        .clk(clk), .rst(rst3),
        .memreq_val(req_val3), .memreq_rdy(req_rdy3), .memreq_type(req_type3),
        .memreq_addr(req_addr3), .memreq_wdata(req_wdata3),
        .memresp_val(resp_val3), .memresp_rdy(resp_rdy3),
        .memresp_type(resp_type3), .memresp_data(resp_data3)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        , .memresp_err(resp_err3)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic t, input logic [31:0] a, input logic [31:0] d);
        req_val = v; req_type = t; req_addr = a; req_wdata = d;
    endtask

    task automatic drive3(input logic v, input logic t, input logic [31:0] a, input logic [31:0] d);
        req_val3 = v; req_type3 = t; req_addr3 = a; req_wdata3 = d;
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        resp_rdy = 1'b1; resp_rdy3 = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive3(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        step();
        check_eq("reset_resp_val", {31'd0, resp_val}, 32'd0);
        check_eq("reset_req_rdy", {31'd0, req_rdy}, 32'd0);
        check_eq("reset_resp_val3", {31'd0, resp_val3}, 32'd0);
        rst = 1'b0; rst3 = 1'b0;
        step();
        check_eq("post_reset_rdy", {31'd0, req_rdy}, 32'd1);
        check_eq("post_reset_rdy3", {31'd0, req_rdy3}, 32'd1);

        // Write then read 0x10, one-cycle latency each.
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        check_eq("wr10_val", {31'd0, resp_val}, 32'd1);
        check_eq("wr10_type", {31'd0, resp_type}, 32'd1);
        check_eq("wr10_data", resp_data, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        check_eq("rd10_val", {31'd0, resp_val}, 32'd1);
        check_eq("rd10_type", {31'd0, resp_type}, 32'd0);
        check_eq("rd10_data", resp_data, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("idle_val", {31'd0, resp_val}, 32'd0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        drive(1'b1, 1'b1, 32'h13, 32'h77);
        step();
        check_eq("mis_wr_err", {31'd0, resp_err}, 32'd1);
        check_eq("mis_wr_data", resp_data, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        check_eq("al_rd_err", {31'd0, resp_err}, 32'd0);
        check_eq("al_rd_data", resp_data, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
`endif

        // Words 0..3 written, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 32'hA0 + 32'(i));
            step();
            check_eq("wrA_type", {31'd0, resp_type}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
            step();
            check_eq("rdA_val", {31'd0, resp_val}, 32'd1);
            check_eq("rdA_data", resp_data, 32'hA0 + 32'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("rdA_drain", {31'd0, resp_val}, 32'd0);

        // Backpressure: two accepted, then stall with a stable head.
        resp_rdy = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("bp_rdy1", {31'd0, req_rdy}, 32'd1);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        step();
        check_eq("bp_rdy_full", {31'd0, req_rdy}, 32'd0);
        check_eq("bp_head0", resp_data, 32'hA0);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        step();
        check_eq("bp_rdy_hold", {31'd0, req_rdy}, 32'd0);
        check_eq("bp_val_hold", {31'd0, resp_val}, 32'd1);
        check_eq("bp_head_hold", resp_data, 32'hA0);
        resp_rdy = 1'b1;
        step();
        check_eq("bp_rdy_back", {31'd0, req_rdy}, 32'd1);
        check_eq("bp_head1", resp_data, 32'hA1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("bp_drained", {31'd0, resp_val}, 32'd0);

        // Address wrap: 0x400 aliases word 0.
        drive(1'b1, 1'b1, 32'h400, 32'h5);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("wrap_data", resp_data, 32'h5);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // LAT=3 instance: write, then a read appears exactly three cycles after its fire.
        drive3(1'b1, 1'b1, 32'h8, 32'h55);
        step();
        drive3(1'b0, 1'b0, 32'h0, 32'h0);
        step(); step(); step();
        drive3(1'b1, 1'b0, 32'h8, 32'h0);
        step();
        drive3(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("lat3_c1", {31'd0, resp_val3}, 32'd0);
        step();
        check_eq("lat3_c2", {31'd0, resp_val3}, 32'd0);
        step();
        check_eq("lat3_c3_val", {31'd0, resp_val3}, 32'd1);
        check_eq("lat3_c3_data", resp_data3, 32'h55);
        step();
        check_eq("lat3_c4", {31'd0, resp_val3}, 32'd0);

        // Reset with one response waiting and one in flight.
        resp_rdy3 = 1'b0;
        drive3(1'b1, 1'b0, 32'h8, 32'h0);
        step();
        step();
        drive3(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("pre_rst_val3", {31'd0, resp_val3}, 32'd1);
        rst3 = 1'b1;
        #1;
        check_eq("rst_val3_now", {31'd0, resp_val3}, 32'd0);
        check_eq("rst_rdy3_now", {31'd0, req_rdy3}, 32'd0);
        step();
        rst3 = 1'b0;
        resp_rdy3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("no_stale3", {31'd0, resp_val3}, 32'd0);
        end
        check_eq("rdy3_after_rst", {31'd0, req_rdy3}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's val/rdy memory request interface; the far end of the instruction-fetch and data request ports driven by the pipelined TinyRV1 datapath/control.
- Accepts read and write requests, performs them on an internal word-addressed array, and returns responses in order.
- Fixed, parameterized latency with a bounded response queue so the processor can apply backpressure.
- Used in processor test harnesses and as the baseline on-chip memory.

Parameters:
- WORDS, 256, number of 32-bit words in the array; power of two, ≥4
- LAT, 1, cycles from request accept to response eligible to leave; range 1..4
- QDEPTH, 2, maximum outstanding requests (pipeline plus queue); ≥1

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- memreq_val  input  1  request valid
- memreq_rdy  output  1  request ready
- memreq_type  input  1  0 = read, 1 = write
- memreq_addr  input  32  byte address
- memreq_wdata  input  32  write data; ignored for reads
- memresp_val  output  1  response valid
- memresp_rdy  input  1  response ready
- memresp_type  output  1  echo of the request type
- memresp_data  output  32  read data; 0 for writes

Behaviour:
- Reset (async, active-high):
  - memresp_val=0 and memreq_rdy=0 while rst is high.
  - Outstanding count, latency pipeline and queue are cleared; all in-flight requests are discarded.
  - Array contents are not reset.
  - memreq_rdy=1 on the first cycle after rst deasserts.
- Fire rules:
  - Request fire = memreq_val & memreq_rdy.
  - Response fire = memresp_val & memresp_rdy.
  - val must not depend combinationally on rdy on either side.
- Word index = memreq_addr[log2(WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*WORDS. addr[1:0] is ignored unless the optional feature is enabled.
- Write: the array is updated at the request-fire edge. Response type=1, data=0.
- Read: the array is read at the request-fire edge. A write accepted in an earlier cycle is visible.
- Outstanding counter (0..QDEPTH):
  - +1 on request fire, −1 on response fire, unchanged when both occur in the same cycle.
  - memreq_rdy = (count < QDEPTH). This is registered-state only, with no combinational path from memresp_rdy.
- Latency pipeline: LAT stages, each holding {val, type, data}. Stage LAT output enqueues into the response queue. The queue never overflows because the counter bounds occupancy.
- Response queue:
  - In-order FIFO of QDEPTH entries; memresp_* shows the head; memresp_val = queue non-empty.
  - Head holds stable while memresp_val=1 and memresp_rdy=0.
  - Enqueue and dequeue in the same cycle are allowed when full or empty.
- Latency: with the queue empty and LAT=1, the response is valid in the cycle after the request fire; in general LAT cycles after.
- Throughput: one request per cycle with memresp_rdy held high, provided QDEPTH ≥ LAT+1. Otherwise throughput is limited to QDEPTH/(LAT+1).
- Responses return strictly in request order; none are dropped or duplicated.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - Adds output port memresp_err (1 bit, travels with the response, 0 at reset).
  - A request with addr[1:0]≠0 sets err=1, suppresses any write, and returns data=0.
  - Aligned requests return err=0.
- Undefined: no memresp_err port; addr[1:0] is silently ignored.

Decomposition:
- Package mem_msg_pkg:
  - MEM_TYPE_READ/MEM_TYPE_WRITE constants
  - mem_req_t struct {type, addr, wdata}
  - mem_resp_t struct {type, data, optional err}
  - DATA_W=32 constant
- Sub-module mem_resp_queue: parameterized-depth FIFO of mem_resp_t with enq/deq, full/empty. It reuses the codebase's Register for pointers.
- The latency pipeline is a generate loop of Register instances.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, then read 0x10 → responses {type=1, data=0} then {type=0, data=0xDEADBEEF}; LAT=1, each response valid exactly one cycle after its fire.
- Writes to words 0..3 with data 0xA0..0xA3, then 4 back-to-back reads with memresp_rdy=1 → read responses on 4 consecutive cycles, in order, data 0xA0..0xA3.
- memresp_rdy=0 with memreq_val=1 held (QDEPTH=2) → 2 requests accepted, then memreq_rdy=0 and the head stays stable. Raising memresp_rdy drains in order and memreq_rdy returns to 1 in the cycle after the first response fire.
- WORDS=256: write 0x5 to addr 0x400, read addr 0x000 → data 0x5 (wrap aliasing).
- LAT=3: single read → memresp_val rises exactly 3 cycles after the fire. Asserting rst mid-flight → memresp_val drops to 0 immediately and no stale response appears after reset.
- With MEM_RESPONDER_ALIGN_CHECK_EN: write 0x77 to addr 0x13 → err=1. Then read 0x10 → err=0 and data shows the prior contents unchanged.
